// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } ctrl_state_e;

    localparam logic [5:0] OP_BR    = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b001111;
    localparam logic [5:0] OP_HALT  = 6'b010001;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detector: flags when the ID instruction must wait for EX/MEM results.
// Latency: purely combinational, same cycle.
// Backpressure: none; raw_hz is itself the stall request consumed by pipe_ctrl.
//
// Ports: ID source fields, EX/MEM destination fields -> raw_hz.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_dest,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_dest,
    output logic       raw_hz
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic any_raw;

    // r0 is hard-wired, so a zero destination never carries a real dependency.
    assign ex_match  = (ex_dest != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == ex_dest)) ||
                        (id_uses_rt && (id_rt == ex_dest)));
    assign mem_match = (mem_dest != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == mem_dest)) ||
                        (id_uses_rt && (id_rt == mem_dest)));

    // Load data is only available after MEM, so forwarding cannot cover it.
    assign load_use = id_valid && ex_memread && ex_regwrite && ex_match;

    // Without forwarding every in-flight writer blocks. WB is excluded because
    // the register file writes before it reads.
    assign any_raw  = id_valid && ((ex_regwrite && ex_match) ||
                                   (mem_regwrite && mem_match));

    assign raw_hz = FORWARD_EN ? load_use : (load_use || any_raw);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/control sequencer: PC and IF/ID enables, squashes, next-PC select, halt drain, stall count.
// Latency: control outputs combinational from state+inputs; halted and stall_cnt registered.
// Backpressure: stalls the front end by dropping pc_write/ifid_write; holds stopped once halted.
//
// Ports: ID decode fields and EX/MEM writeback info in; pc_write, pc_sel_target,
// ifid_write, ifid_flush, idex_flush, halted, stall_cnt out.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter bit FORWARD_EN   = 1'b1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_halt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_dest,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_dest,
    input  logic             ex_br_valid,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             pc_sel_target,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          raw_hz;
    logic          count_stall;

    hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_hazard (
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_dest      (ex_dest),
        .mem_regwrite (mem_regwrite),
        .mem_dest     (mem_dest),
        .raw_hz       (raw_hz)
    );

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write      = 1'b1;
        pc_sel_target = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;

        case (state_q)
            RUN: begin
                if (raw_hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_is_halt) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    drain_d    = DW'(DRAIN_CYCLES);
                    state_d    = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                end else if (id_is_branch) begin
                    // Hold PC at branch+4 until EX says which way to go.
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (!ex_br_valid) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                end else if (ex_br_taken) begin
                    pc_sel_target = 1'b1;
                    ifid_flush    = 1'b1;
                    state_d       = RUN;
                end else begin
                    // Held fall-through instruction is still valid; let it into ID.
                    state_d = RUN;
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                drain_d    = drain_q - DW'(1);
                if (drain_q <= DW'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // While reset is held the front end is frozen and both stages are squashed.
        if (!rst) begin
            pc_write      = 1'b0;
            pc_sel_target = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end
    end

    assign count_stall = ((state_q == RUN) || (state_q == BR_WAIT)) && !pc_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halted  <= (state_d == HALTED);
            if (count_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
